control_multiciclo: RTL and testbench
=====================================

// Module: control_multiciclo
// PURPOSE
//  Multicycle control unit: the driving end of the datapath control interface. Consumes the fetched instruction and ALU zero flag.
//  Sequences each instruction over 3-4+ cycles and produces every datapath control strobe, plus a PC write enable.
//  Sits beside the datapath in the top level. Adds a data-memory ready handshake, a wait timeout, and a retired-instruction counter.
// PARAMETERS
//  MEM_TIMEOUT  15  max cycles waiting for mem_ready in MEM_RD/MEM_WR before entering HALT
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clk          in   1      system clock, rising edge
//  reset_UC     in   1      asynchronous, active-low reset
//  inst         in   32     instruction from instruction memory (stable while PC unchanged)
//  zero         in   1      ALU zero flag
//  mem_ready    in   1      data memory done (read data valid / write accepted)
//  pcEn         out  1      PC load enable
//  pcSrc        out  1      0: PC+4, 1: PC+imm
//  aluSrc       out  1      0: rd2, 1: immediate
//  regWrite     out  1      register-file write strobe
//  memWrite     out  1      data-memory write strobe
//  mem_req      out  1      data-memory access request
//  rscSrc       out  2      wd3 select: 00 ALU, 01 memory, 10 PC+4
//  aluControl   out  3      000 add, 001 sub, 010 and, 011 or, 101 slt
//  type_sel     out  3      format to SE/PD: 000 R, 001 I, 010 S, 011 B, 100 J
//  instret      out  CNT_W  instructions retired since reset
//  halted       out  1      1 while in HALT
// BEHAVIOUR
//  - Reset (async, low): state=FETCH, IR=0, instret=0, timeout cnt=0. All strobes 0; rscSrc=00, aluControl=000, type_sel=000, halted=0, immediately.
//  - IR captures inst on the FETCH->DECODE edge. All decoding uses IR; outputs are Moore from state+IR, except pcSrc in BRANCH (=zero).
//  - Opcodes: 0110011 R, 0010011 I-ALU, 0000011 lw, 0100011 sw, 1100011 beq, 1101111 jal. Any other opcode -> HALT.
//  - ALU decode (R/I): f3 000 add (sub if R & f7[5]), 010 slt, 110 or, 111 and. Other f3 -> HALT. lw/sw: add. beq: sub.
//  - States/transitions:
//    FETCH -> DECODE, unconditionally.
//    DECODE -> EXEC | MEM_RD | MEM_WR | BRANCH | JAL_LINK | HALT, selected by opcode.
//    EXEC: regWrite=1, rscSrc=00, aluSrc=(I), pcEn=1, pcSrc=0 -> FETCH.
//    MEM_RD: aluSrc=1, type I, mem_req=1; hold until mem_ready=1 -> MEM_WB.
//    MEM_WB: regWrite=1, rscSrc=01, aluSrc=1, pcEn=1 -> FETCH.
//    MEM_WR: aluSrc=1, type S, mem_req=1, memWrite=1; hold while !mem_ready. On the mem_ready cycle, pcEn=1 -> FETCH.
//    BRANCH: type B, aluSrc=0, aluControl=001, pcEn=1, pcSrc=zero -> FETCH.
//    JAL_LINK: type J, regWrite=1, rscSrc=10, pcSrc=0 -> JAL_JUMP.
//    JAL_JUMP: type J, pcEn=1, pcSrc=1 -> FETCH.
//    HALT: all strobes 0, halted=1; exits only on reset.
//  - Timeout counter: cleared on entry to MEM_RD/MEM_WR, increments each waiting cycle.
//    If it reaches MEM_TIMEOUT while mem_ready is still 0 -> HALT; no regWrite/pcEn is issued.
//    mem_ready in the same cycle the count reaches the limit wins (normal completion).
//  - Latency: R/I/beq 3 cycles; jal 4; lw 4+waits; sw 3+waits.
//  - instret +1 on every cycle with pcEn=1. Wraps modulo 2^CNT_W; never increments in HALT.
//  - Invariants: at most one of regWrite/memWrite per cycle; pcEn exactly once per retired instruction.
//    mem_ready is ignored outside MEM_RD/MEM_WR.
//  - Reset asserted mid-instruction aborts it: no partial strobe survives, and instret is not incremented for the aborted instruction.
// TESTING
//  - add x3,x1,x2 (0x002081B3): states FETCH,DECODE,EXEC; EXEC has regWrite=1, rscSrc=00, aluControl=000, pcEn=1; instret 0->1.
//  - lw, mem_ready low 2 cycles: MEM_RD held 3 cycles, then MEM_WB with regWrite=1, rscSrc=01, pcEn=1; total 6 cycles.
//  - beq with zero=1 then zero=0: BRANCH pcSrc=1 then 0; aluControl=001; regWrite=0.
//  - jal: JAL_LINK regWrite=1, rscSrc=10, pcEn=0; then JAL_JUMP pcEn=1, pcSrc=1, regWrite=0.
//  - sw with mem_ready held 0 (MEM_TIMEOUT=15): enters HALT after 15 wait cycles, halted=1, instret unchanged.
//    Same check for opcode 0x7F: HALT directly from DECODE.
//  - reset_UC low mid MEM_WR: memWrite drops without waiting for clk; after release, FETCH and instret=0.

Source files
------------

// File: rtl/control_multiciclo_if.sv
// Control bundle between the multicycle control unit (master) and the datapath (slave).
interface control_multiciclo_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      inst;
  logic             zero;
  logic             mem_ready;
  logic             pcEn;
  logic             pcSrc;
  logic             aluSrc;
  logic             regWrite;
  logic             memWrite;
  logic             mem_req;
  logic [1:0]       rscSrc;
  logic [2:0]       aluControl;
  logic [2:0]       type_sel;
  logic [CNT_W-1:0] instret;
  logic             halted;

  modport master (
    input  inst, zero, mem_ready,
    output pcEn, pcSrc, aluSrc, regWrite, memWrite, mem_req,
    output rscSrc, aluControl, type_sel, instret, halted
  );

  modport slave (
    output inst, zero, mem_ready,
    input  pcEn, pcSrc, aluSrc, regWrite, memWrite, mem_req,
    input  rscSrc, aluControl, type_sel, instret, halted
  );
endinterface

// File: rtl/control_multiciclo.sv
// Multicycle control unit: sequences each instruction from the latched IR, waits on
// data memory with a timeout, and counts retired instructions.
module control_multiciclo #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input logic                  clk,
  input logic                  reset_UC,
  control_multiciclo_if.master ctl
);
  localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM_RD, S_MEM_WB,
    S_MEM_WR, S_BRANCH, S_JAL_LINK, S_JAL_JUMP, S_HALT
  } state_t;

  state_t           state, state_nx;
  logic [31:0]      ir;
  logic [TW-1:0]    tmo_cnt;
  logic [CNT_W-1:0] instret;

  logic [6:0] op;
  logic [2:0] f3;
  logic       f7b5;
  logic [2:0] alu_op;
  logic       alu_ok;
  logic       tmo_hit;

  logic       pc_en, pc_src, alu_src, reg_write, mem_write, mem_req;
  logic [1:0] rsc_src;
  logic [2:0] alu_ctl, type_sel;

  assign op      = ir[6:0];
  assign f3      = ir[14:12];
  assign f7b5    = ir[30];
  assign tmo_hit = (tmo_cnt == TW'(MEM_TIMEOUT - 1));

  logic unused_ir;
  assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

  always_ff @(posedge clk or negedge reset_UC) begin
    if (!reset_UC) begin
      state   <= S_FETCH;
      ir      <= '0;
      tmo_cnt <= '0;
      instret <= '0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH) ir <= ctl.inst;
      // Count only while waiting; any other state leaves it cleared for the next access.
      if (state == S_MEM_RD || state == S_MEM_WR) tmo_cnt <= tmo_cnt + 1'b1;
      else                                        tmo_cnt <= '0;
      if (pc_en) instret <= instret + 1'b1;
    end
  end

  always_comb begin
    alu_ok = 1'b1;
    alu_op = 3'b000;
    case (f3)
      3'b000:  alu_op = (op == OP_R && f7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_op = 3'b101;
      3'b110:  alu_op = 3'b011;
      3'b111:  alu_op = 3'b010;
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_nx  = state;
    pc_en     = 1'b0;
    pc_src    = 1'b0;
    alu_src   = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    mem_req   = 1'b0;
    rsc_src   = 2'b00;
    alu_ctl   = 3'b000;
    type_sel  = 3'b000;
    case (state)
      S_FETCH: state_nx = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_R, OP_I: state_nx = alu_ok ? S_EXEC : S_HALT;
          OP_LW:      state_nx = S_MEM_RD;
          OP_SW:      state_nx = S_MEM_WR;
          OP_BEQ:     state_nx = S_BRANCH;
          OP_JAL:     state_nx = S_JAL_LINK;
          default:    state_nx = S_HALT;
        endcase
      end
      S_EXEC: begin
        reg_write = 1'b1;
        alu_src   = (op == OP_I);
        alu_ctl   = alu_op;
        type_sel  = (op == OP_I) ? 3'b001 : 3'b000;
        pc_en     = 1'b1;
        state_nx  = S_FETCH;
      end
      S_MEM_RD: begin
        alu_src  = 1'b1;
        type_sel = 3'b001;
        mem_req  = 1'b1;
        if (ctl.mem_ready)  state_nx = S_MEM_WB;
        else if (tmo_hit)   state_nx = S_HALT;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        rsc_src   = 2'b01;
        alu_src   = 1'b1;
        type_sel  = 3'b001;
        pc_en     = 1'b1;
        state_nx  = S_FETCH;
      end
      S_MEM_WR: begin
        alu_src   = 1'b1;
        type_sel  = 3'b010;
        mem_req   = 1'b1;
        mem_write = 1'b1;
        // The store retires in the same cycle the memory accepts it.
        pc_en     = ctl.mem_ready;
        if (ctl.mem_ready)  state_nx = S_FETCH;
        else if (tmo_hit)   state_nx = S_HALT;
      end
      S_BRANCH: begin
        type_sel = 3'b011;
        alu_ctl  = 3'b001;
        pc_en    = 1'b1;
        pc_src   = ctl.zero;
        state_nx = S_FETCH;
      end
      S_JAL_LINK: begin
        type_sel  = 3'b100;
        reg_write = 1'b1;
        rsc_src   = 2'b10;
        state_nx  = S_JAL_JUMP;
      end
      S_JAL_JUMP: begin
        type_sel = 3'b100;
        pc_en    = 1'b1;
        pc_src   = 1'b1;
        state_nx = S_FETCH;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_HALT;
    endcase
  end

  assign ctl.pcEn       = pc_en;
  assign ctl.pcSrc      = pc_src;
  assign ctl.aluSrc     = alu_src;
  assign ctl.regWrite   = reg_write;
  assign ctl.memWrite   = mem_write;
  assign ctl.mem_req    = mem_req;
  assign ctl.rscSrc     = rsc_src;
  assign ctl.aluControl = alu_ctl;
  assign ctl.type_sel   = type_sel;
  assign ctl.instret    = instret;
  assign ctl.halted     = (state == S_HALT);
endmodule

// File: tb/tb_control_multiciclo.sv
// Bench for control_multiciclo: per-instruction expected cycle schedules built from
// the instruction-level rules, driven with directed and random instructions.
module tb_control_multiciclo;
  localparam int unsigned TMO = 15;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic clk = 1'b0;
  logic reset_UC;
  always #5 clk = ~clk;

  control_multiciclo_if #(.CNT_W(32)) bus ();

  control_multiciclo #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk      (clk),
    .reset_UC (reset_UC),
    .ctl      (bus)
  );

  typedef struct {
    logic       mr, z;
    logic       pcEn, regWrite, memWrite, mem_req, halted;
    bit         ck_pcs; logic       pcSrc;
    bit         ck_als; logic       aluSrc;
    bit         ck_rsc; logic [1:0] rscSrc;
    bit         ck_alu; logic [2:0] aluControl;
    bit         ck_typ; logic [2:0] type_sel;
  } cyc_t;

  cyc_t        sched[$];
  bit          planned_halt;
  int unsigned model_ret;
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic cyc_t base_cyc();
    cyc_t c;
    c = '{default: '0};
    c.mr = 1'($urandom_range(0, 1));
    c.z  = 1'($urandom_range(0, 1));
    return c;
  endfunction

  function automatic cyc_t mem_cyc(input bit is_sw, input logic ready);
    cyc_t c;
    c = base_cyc();
    c.mr = ready; c.mem_req = 1'b1; c.memWrite = is_sw; c.pcEn = is_sw & ready;
    c.ck_als = 1; c.aluSrc = 1'b1;
    c.ck_alu = 1; c.aluControl = 3'b000;
    c.ck_typ = 1; c.type_sel = is_sw ? 3'b010 : 3'b001;
    return c;
  endfunction

  function automatic logic [2:0] alu_ref(input bit is_r, input logic [2:0] f3, input logic f7b5);
    case (f3)
      3'b000:  return (is_r && f7b5) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  // Builds the expected cycle-by-cycle outputs of one instruction from its opcode and fields.
  function automatic void plan(input logic [31:0] ins, input int unsigned waits, input int zsel);
    cyc_t c;
    logic [6:0] op;
    logic [2:0] f3;
    bit halt_now;
    op = ins[6:0]; f3 = ins[14:12]; halt_now = 0;
    sched.delete();
    sched.push_back(base_cyc());
    sched.push_back(base_cyc());
    if (op == OP_R || op == OP_I) begin
      if (!(f3 inside {3'b000, 3'b010, 3'b110, 3'b111})) halt_now = 1;
      else begin
        c = base_cyc();
        c.pcEn = 1; c.regWrite = 1;
        c.ck_pcs = 1; c.pcSrc = 1'b0;
        c.ck_als = 1; c.aluSrc = (op == OP_I);
        c.ck_rsc = 1; c.rscSrc = 2'b00;
        c.ck_alu = 1; c.aluControl = alu_ref(op == OP_R, f3, ins[30]);
        c.ck_typ = 1; c.type_sel = (op == OP_I) ? 3'b001 : 3'b000;
        sched.push_back(c);
      end
    end else if (op == OP_LW || op == OP_SW) begin
      for (int unsigned k = 0; k < waits && k < TMO; k++) sched.push_back(mem_cyc(op == OP_SW, 1'b0));
      if (waits >= TMO) halt_now = 1;
      else begin
        sched.push_back(mem_cyc(op == OP_SW, 1'b1));
        if (op == OP_LW) begin
          c = base_cyc();
          c.pcEn = 1; c.regWrite = 1;
          c.ck_rsc = 1; c.rscSrc = 2'b01;
          c.ck_als = 1; c.aluSrc = 1'b1;
          sched.push_back(c);
        end
      end
    end else if (op == OP_BEQ) begin
      c = base_cyc();
      if (zsel >= 0) c.z = zsel[0];
      c.pcEn = 1;
      c.ck_pcs = 1; c.pcSrc = c.z;
      c.ck_als = 1; c.aluSrc = 1'b0;
      c.ck_alu = 1; c.aluControl = 3'b001;
      c.ck_typ = 1; c.type_sel = 3'b011;
      sched.push_back(c);
    end else if (op == OP_JAL) begin
      c = base_cyc();
      c.regWrite = 1;
      c.ck_rsc = 1; c.rscSrc = 2'b10;
      c.ck_pcs = 1; c.pcSrc = 1'b0;
      c.ck_typ = 1; c.type_sel = 3'b100;
      sched.push_back(c);
      c = base_cyc();
      c.pcEn = 1;
      c.ck_pcs = 1; c.pcSrc = 1'b1;
      c.ck_typ = 1; c.type_sel = 3'b100;
      sched.push_back(c);
    end else begin
      halt_now = 1;
    end
    if (halt_now)
      for (int k = 0; k < 4; k++) begin
        c = base_cyc();
        c.halted = 1;
        sched.push_back(c);
      end
    planned_halt = halt_now;
  endfunction

  // Entered and left at a falling edge; checks each cycle mid-cycle.
  task automatic run_plan(input string nm, input int unsigned ncyc);
    int unsigned n;
    cyc_t c;
    n = (ncyc == 0) ? sched.size() : ncyc;
    for (int unsigned i = 0; i < n; i++) begin
      c = sched[i];
      if (i > 0) bus.inst = $urandom;
      bus.mem_ready = c.mr;
      bus.zero      = c.z;
      #1;
      chk({nm, " pcEn"},     bus.pcEn,     c.pcEn);
      chk({nm, " regWrite"}, bus.regWrite, c.regWrite);
      chk({nm, " memWrite"}, bus.memWrite, c.memWrite);
      chk({nm, " mem_req"},  bus.mem_req,  c.mem_req);
      chk({nm, " halted"},   bus.halted,   c.halted);
      chk({nm, " instret"},  bus.instret,  model_ret);
      if (c.ck_pcs) chk({nm, " pcSrc"},      bus.pcSrc,      c.pcSrc);
      if (c.ck_als) chk({nm, " aluSrc"},     bus.aluSrc,     c.aluSrc);
      if (c.ck_rsc) chk({nm, " rscSrc"},     bus.rscSrc,     c.rscSrc);
      if (c.ck_alu) chk({nm, " aluControl"}, bus.aluControl, c.aluControl);
      if (c.ck_typ) chk({nm, " type_sel"},   bus.type_sel,   c.type_sel);
      if (c.pcEn) model_ret++;
      @(negedge clk);
    end
  endtask

  task automatic exec(input string nm, input logic [31:0] ins, input int unsigned waits, input int zsel);
    plan(ins, waits, zsel);
    bus.inst = ins;
    run_plan(nm, 0);
    chk({nm, " instret after"}, bus.instret, model_ret);
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, " pcEn"},       bus.pcEn,       1'b0);
    chk({nm, " pcSrc"},      bus.pcSrc,      1'b0);
    chk({nm, " aluSrc"},     bus.aluSrc,     1'b0);
    chk({nm, " regWrite"},   bus.regWrite,   1'b0);
    chk({nm, " memWrite"},   bus.memWrite,   1'b0);
    chk({nm, " mem_req"},    bus.mem_req,    1'b0);
    chk({nm, " rscSrc"},     bus.rscSrc,     2'b00);
    chk({nm, " aluControl"}, bus.aluControl, 3'b000);
    chk({nm, " type_sel"},   bus.type_sel,   3'b000);
    chk({nm, " halted"},     bus.halted,     1'b0);
    chk({nm, " instret"},    bus.instret,    32'd0);
  endtask

  task automatic do_reset(input string nm);
    reset_UC = 1'b0;
    #1;
    check_reset_state(nm);
    @(negedge clk);
    reset_UC  = 1'b1;
    model_ret = 0;
  endtask

  function automatic logic [31:0] gen_inst();
    logic [31:0] ins;
    logic [6:0]  op;
    int unsigned k;
    logic [2:0]  f3v [4];
    f3v = '{3'b000, 3'b010, 3'b110, 3'b111};
    ins = $urandom;
    k = $urandom_range(0, 19);
    if (k <= 4 || k == 17) begin
      ins[6:0] = OP_R;
      ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      if (k != 17) ins[14:12] = f3v[$urandom_range(0, 3)];
    end else if (k <= 8 || k == 19) begin
      ins[6:0] = OP_I;
      if (k != 19) ins[14:12] = f3v[$urandom_range(0, 3)];
    end else if (k <= 10) ins[6:0] = OP_LW;
    else if (k <= 12)     ins[6:0] = OP_SW;
    else if (k <= 14)     ins[6:0] = OP_BEQ;
    else if (k <= 16)     ins[6:0] = OP_JAL;
    else begin
      do op = 7'($urandom);
      while (op inside {OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_JAL});
      ins[6:0] = op;
    end
    return ins;
  endfunction

  initial begin
    logic [31:0] ins;
    int unsigned w;
    reset_UC      = 1'b0;
    bus.inst      = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    model_ret     = 0;
    @(negedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    reset_UC = 1'b1;

    exec("add",      32'h002081B3, 0, -1);
    exec("sub",      32'h402081B3, 0, -1);
    exec("lw_w2",    32'h0000A283, 2, -1);
    exec("beq_z1",   32'h00208063, 0, 1);
    exec("beq_z0",   32'h00208063, 0, 0);
    exec("jal",      32'h008000EF, 0, -1);
    exec("sw_w14",   32'h0020A023, 14, -1);
    exec("lw_w14",   32'h0000A283, 14, -1);

    for (int n = 0; n < 200; n++) begin
      ins = gen_inst();
      w = ($urandom_range(0, 19) == 0) ? $urandom_range(14, 15) : $urandom_range(0, 3);
      exec("rand", ins, w, -1);
      if (planned_halt) do_reset("rand reset");
    end

    exec("sw_tmo", 32'h0020A023, 15, -1);
    chk("sw_tmo planned halt", 32'(planned_halt), 32'd1);
    do_reset("sw_tmo reset");
    exec("illegal", 32'h0000007F, 0, -1);
    do_reset("illegal reset");

    // Abort a store mid-wait with an asynchronous reset.
    exec("pre_add", 32'h002081B3, 0, -1);
    plan(32'h0020A023, 15, -1);
    bus.inst = 32'h0020A023;
    run_plan("sw_abort", 3);
    bus.mem_ready = 1'b0;
    #1;
    chk("sw_abort memWrite before", bus.memWrite, 1'b1);
    #2;
    reset_UC = 1'b0;
    #1;
    chk("sw_abort memWrite", bus.memWrite, 1'b0);
    chk("sw_abort mem_req",  bus.mem_req,  1'b0);
    chk("sw_abort pcEn",     bus.pcEn,     1'b0);
    chk("sw_abort instret",  bus.instret,  32'd0);
    @(negedge clk);
    reset_UC  = 1'b1;
    model_ret = 0;
    exec("post_add", 32'h002081B3, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $fatal(1, "FAIL timeout: observed no finish, expected finish");
  end
endmodule
